bsg_two_fifo_width_p33: RTL and testbench

- Two-entry elastic FIFO, 33 bits wide, with ready/valid-in and valid/yumi-out handshakes.
- Sits directly downstream of the 33-bit bitwise NOR stage. Registers its output vector and decouples it from the consumer's backpressure.
- Sustains one transfer per cycle with no combinational path from yumi_i to ready_o.

---
 rtl/bsg_nor2_pkg.sv | 5 +
 rtl/bsg_mem_1r1w_2x33.sv | 20 ++
 rtl/bsg_two_fifo_width_p33.sv | 47 ++++
 tb/tb_bsg_two_fifo_width_p33.sv | 131 +++++++++++++
 4 files changed

// File: rtl/bsg_nor2_pkg.sv
// bsg_nor2_pkg: shared 33-bit word width and word type for the NOR stage and its output FIFO
package bsg_nor2_pkg;
  localparam int nor_width_gp = 33;
  typedef logic [nor_width_gp-1:0] nor_word_t;
endpackage

// File: rtl/bsg_mem_1r1w_2x33.sv
// bsg_mem_1r1w_2x33: 2x33 register file, sync write/clear (clk_i, reset_i, w_v_i, w_addr_i, w_data_i), async read (r_addr_i -> r_data_o)
module bsg_mem_1r1w_2x33
  import bsg_nor2_pkg::*;
(
  input  logic      clk_i,
  input  logic      reset_i,
  input  logic      w_v_i,
  input  logic      w_addr_i,
  input  nor_word_t w_data_i,
  input  logic      r_addr_i,
  output nor_word_t r_data_o
);
  nor_word_t mem [2];
  always_ff @(posedge clk_i)
    if (reset_i) begin
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (w_v_i) mem[w_addr_i] <= w_data_i;
  assign r_data_o = mem[r_addr_i];
endmodule

// File: rtl/bsg_two_fifo_width_p33.sv
// bsg_two_fifo_width_p33: 2-entry elastic FIFO; in v_i/data_i/ready_o, out v_o/data_o/yumi_i, clk_i, sync reset_i
module bsg_two_fifo_width_p33
  import bsg_nor2_pkg::*;
(
  input  logic      clk_i,
  input  logic      reset_i,
  input  logic      v_i,
  input  nor_word_t data_i,
  output logic      ready_o,
  output logic      v_o,
  output nor_word_t data_o,
  input  logic      yumi_i
);
  logic rptr_r, wptr_r, full_r, empty_r, enq, deq;
  assign ready_o = ~full_r & ~reset_i;
  assign v_o = ~empty_r;
  assign enq = v_i & ready_o;
  assign deq = yumi_i;
  always_ff @(posedge clk_i)
    if (reset_i) begin
      rptr_r  <= 1'b0;
      wptr_r  <= 1'b0;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
    end else begin
      if (enq) wptr_r <= ~wptr_r;
      if (deq) rptr_r <= ~rptr_r;
      if (enq & ~deq) begin
        empty_r <= 1'b0;
        full_r  <= (rptr_r == ~wptr_r);
      end
      if (deq & ~enq) begin
        full_r  <= 1'b0;
        empty_r <= (wptr_r == ~rptr_r);
      end
    end
  bsg_mem_1r1w_2x33 mem (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .w_v_i   (enq),
    .w_addr_i(wptr_r),
    .w_data_i(data_i),
    .r_addr_i(rptr_r),
    .r_data_o(data_o)
  );
  assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o);
endmodule

// File: tb/tb_bsg_two_fifo_width_p33.sv
// tb_bsg_two_fifo_width_p33: scoreboard bench for the two-entry FIFO with directed and random traffic
module tb_bsg_two_fifo_width_p33;
  import bsg_nor2_pkg::*;
  logic clk = 0, reset_i = 1, v_i = 0, yumi_i = 0, ready_o, v_o;
  nor_word_t data_i = '0, data_o;
  nor_word_t sbq [$];
  int checks = 0, failures = 0, mode = 0;
  logic last_acc = 0;
  bsg_two_fifo_width_p33 dut (
    .clk_i  (clk),
    .reset_i(reset_i),
    .v_i    (v_i),
    .data_i (data_i),
    .ready_o(ready_o),
    .v_o    (v_o),
    .data_o (data_o),
    .yumi_i (yumi_i)
  );
  always #5 clk = ~clk;
  task automatic chk(string n, nor_word_t act, nor_word_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
    #1;
  endtask
  task automatic drive(logic v, nor_word_t d);
    v_i = v;
    data_i = d;
    last_acc = v && ready_o;
    if (last_acc) sbq.push_back(d);
  endtask
  always @(negedge clk) begin
    logic take;
    if (reset_i) yumi_i = 0;
    else begin
      chk("v_o", {32'b0, v_o}, {32'b0, sbq.size() > 0});
      chk("ready_o", {32'b0, ready_o}, {32'b0, sbq.size() < 2});
      take = v_o && (mode == 1 || (mode == 2 && $urandom_range(1) == 1));
      yumi_i = take;
      if (take && sbq.size() > 0) chk("data_o", data_o, sbq.pop_front());
    end
  end
  initial begin
    nor_word_t a, b;
    reset_i = 1;
    drive(1, 33'h1_FFFF_FFFF);
    repeat (3) begin
      @(negedge clk);
      chk("rst_v_o", {32'b0, v_o}, '0);
      chk("rst_data_o", data_o, '0);
      chk("rst_ready_o", {32'b0, ready_o}, '0);
      #1;
    end
    sbq.delete();
    v_i = 0;
    reset_i = 0;
    step();
    chk("post_rst_data_o", data_o, '0);
    chk("post_rst_ready_o", {32'b0, ready_o}, 33'h1);
    mode = 1;
    drive(1, 33'h0_0000_0001);
    step();
    drive(0, '0);
    step();
    step();
    chk("single_v_o", {32'b0, v_o}, '0);
    mode = 0;
    drive(1, 33'h1_0000_0000);
    step();
    drive(1, 33'h0_AAAA_AAAA);
    step();
    chk("full_ready_o", {32'b0, ready_o}, '0);
    repeat (4) begin
      drive(1, 33'h0_5555_5555);
      step();
      chk("full_hold_ready_o", {32'b0, ready_o}, '0);
    end
    drive(0, '0);
    mode = 1;
    repeat (4) step();
    chk("drained", sbq.size(), '0);
    for (int i = 0; i < 40; i++) begin
      drive(1, nor_word_t'(i));
      chk("stream_ready_o", {32'b0, ready_o}, 33'h1);
      step();
    end
    drive(0, '0);
    repeat (3) step();
    mode = 0;
    drive(1, 33'h0_0F0F_0F0F);
    step();
    drive(1, 33'h1_F0F0_F0F0);
    step();
    drive(0, '0);
    chk("pre_rst_full", {32'b0, ready_o}, '0);
    reset_i = 1;
    sbq.delete();
    step();
    reset_i = 0;
    step();
    chk("midrst_data_o", data_o, '0);
    chk("midrst_v_o", {32'b0, v_o}, '0);
    chk("midrst_ready_o", {32'b0, ready_o}, 33'h1);
    mode = 1;
    drive(1, 33'h1_2345_6789);
    step();
    drive(0, '0);
    repeat (3) step();
    mode = 2;
    for (int c = 0; c < 10000; c++) begin
      if (v_i && !last_acc) drive(1, data_i);
      else begin
        a = {$urandom_range(1), $urandom};
        b = {$urandom_range(1), $urandom};
        drive($urandom_range(1) == 1, ~(a | b));
      end
      step();
    end
    drive(0, '0);
    mode = 1;
    for (int c = 0; c < 10 && sbq.size() > 0; c++) step();
    chk("final_empty", sbq.size(), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
